adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 158 +++++++++++++++
 tb/tb_adder_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Round-robin arbiter that time-shares one external adder of fixed latency
// among N_REQ requesters, returning each sum with a one-cycle done pulse.
`timescale 1ns/1ps
module adder_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [2*N_REQ-1:0]   a_in,
  input  logic [2*N_REQ-1:0]   b_in,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  output logic [2:0]           sum,
  output logic                 busy,
  output logic [1:0]           add_a,
  output logic [1:0]           add_b,
  input  logic [2:0]           add_s
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [IW-1:0]   ptr_r, ptr_s;
  logic [IW-1:0]   owner_r, owner_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [IW-1:0]   sel_idx_s;
  logic            sel_valid_s;
  logic            hit_s;
  logic [N_REQ-1:0] gnt_s, done_s;
  logic [2:0]      sum_s;
  logic            busy_s;
  logic [1:0]      add_a_s, add_b_s;

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int offs);
    int j;
    j = int'(base) + offs;
    j = (j >= N_REQ) ? (j - N_REQ) : j;
    return IW'(j);
  endfunction

  function automatic logic [1:0] operand_at(input logic [2*N_REQ-1:0] v, input logic [IW-1:0] idx);
    logic [1:0] r;
    r = 2'b00;
    for (int i = 0; i < N_REQ; i++) begin
      r = (int'(idx) == i) ? v[2*i +: 2] : r;
    end
    return r;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [N_REQ-1:0] r;
    for (int i = 0; i < N_REQ; i++) begin
      r[i] = (int'(idx) == i);
    end
    return r;
  endfunction

  // Round-robin pick: first requester at or after ptr, wrapping around.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_idx_s   = '0;
    hit_s       = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      hit_s       = req[wrap_idx(ptr_r, k)] && !sel_valid_s;
      sel_idx_s   = hit_s ? wrap_idx(ptr_r, k) : sel_idx_s;
      sel_valid_s = sel_valid_s | hit_s;
    end
  end

  // Next-state and next-output computation for the transaction FSM.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    owner_s = owner_r;
    cnt_s   = cnt_r;
    gnt_s   = gnt;
    done_s  = '0;
    sum_s   = sum;
    busy_s  = busy;
    add_a_s = add_a;
    add_b_s = add_b;
    case (state_r)
      IDLE: begin
        if (sel_valid_s) begin
          state_s = WAIT;
          owner_s = sel_idx_s;
          gnt_s   = onehot(sel_idx_s);
          cnt_s   = CW'(ADD_LAT);
          add_a_s = operand_at(a_in, sel_idx_s);
          add_b_s = operand_at(b_in, sel_idx_s);
          busy_s  = 1'b1;
        end else begin
          gnt_s  = '0;
          busy_s = 1'b0;
        end
      end
      WAIT: begin
        cnt_s = cnt_r - CW'(1);
        // The sum is taken on the same edge the counter hits zero.
        if (cnt_r <= CW'(1)) begin
          state_s = RESP;
          sum_s   = add_s;
          done_s  = gnt;
        end else begin
          state_s = WAIT;
        end
      end
      RESP: begin
        state_s = IDLE;
        gnt_s   = '0;
        busy_s  = 1'b0;
        ptr_s   = wrap_idx(owner_r, 1);
      end
      default: begin
        state_s = IDLE;
        gnt_s   = '0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      ptr_r   <= '0;
      owner_r <= '0;
      cnt_r   <= '0;
      gnt     <= '0;
      done    <= '0;
      sum     <= 3'd0;
      busy    <= 1'b0;
      add_a   <= 2'd0;
      add_b   <= 2'd0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      owner_r <= owner_s;
      cnt_r   <= cnt_s;
      gnt     <= gnt_s;
      done    <= done_s;
      sum     <= sum_s;
      busy    <= busy_s;
      add_a   <= add_a_s;
      add_b   <= add_b_s;
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: one instance with ADD_LAT=1, one with ADD_LAT=3.
`timescale 1ns/1ps
module tb_adder_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N-1:0]   req1, gnt1, done1, req3, gnt3, done3;
  logic [2*N-1:0] a1, b1, a3, b3;
  logic [2:0]     sum1, add_s1, sum3, add_s3;
  logic           busy1, busy3;
  logic [1:0]     add_a1, add_b1, add_a3, add_b3;
  logic [2:0]     pipe0, pipe1;

  // External adders: combinational for latency 1, two register stages for latency 3.
  assign add_s1 = {1'b0, add_a1} + {1'b0, add_b1};
  always @(posedge clk) begin
    pipe0 <= {1'b0, add_a3} + {1'b0, add_b3};
    pipe1 <= pipe0;
  end
  assign add_s3 = pipe1;

  adder_arbiter #(.N_REQ(N), .ADD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .a_in(a1), .b_in(b1),
    .gnt(gnt1), .done(done1), .sum(sum1), .busy(busy1),
    .add_a(add_a1), .add_b(add_b1), .add_s(add_s1));

  adder_arbiter #(.N_REQ(N), .ADD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .a_in(a3), .b_in(b3),
    .gnt(gnt3), .done(done3), .sum(sum3), .busy(busy3),
    .add_a(add_a3), .add_b(add_b3), .add_s(add_s3));

  int checks = 0;
  int failures = 0;
  int         exp_idx[$];
  logic [2:0] exp_sum[$];

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic set_op1(input int i, input logic [1:0] a, input logic [1:0] b);
    a1[2*i +: 2] = a;
    b1[2*i +: 2] = b;
  endtask

  task automatic push(input int i, input int a, input int b);
    exp_idx.push_back(i);
    exp_sum.push_back(3'(a + b));
  endtask

  task automatic wait_done1(input int limit, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (n < limit && !ok) begin
      @(negedge clk);
      n++;
      ok = (done1 != '0);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req1 = 4'hF; req3 = 4'hF;
    a1 = 8'hFF; b1 = 8'hFF; a3 = 8'hFF; b3 = 8'hFF;
    repeat (3) @(negedge clk);
    checks++; if (gnt1 !== 4'h0) begin failures++; $display("FAIL reset_gnt: got %b expected 0000", gnt1); end
    checks++; if (done1 !== 4'h0) begin failures++; $display("FAIL reset_done: got %b expected 0000", done1); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy1); end
    checks++; if (sum1 !== 3'd0) begin failures++; $display("FAIL reset_sum: got %0d expected 0", sum1); end
    checks++; if ({add_a1, add_b1} !== 4'h0) begin failures++; $display("FAIL reset_add_ops: got %h expected 0", {add_a1, add_b1}); end
    checks++; if ({gnt3, done3, busy3, sum3, add_a3, add_b3} !== 16'h0) begin
      failures++; $display("FAIL reset_dut3: got %h expected 0", {gnt3, done3, busy3, sum3, add_a3, add_b3}); end
    req1 = 4'h0; req3 = 4'h0;
    a1 = 8'h00; b1 = 8'h00; a3 = 8'h00; b3 = 8'h00;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int i;
    logic [2:0] s;
    req1 = 4'b0001;
    set_op1(0, 2'd1, 2'd1);
    push(0, 1, 1);
    @(negedge clk);
    checks++; if (gnt1 !== 4'b0001) begin failures++; $display("FAIL single_gnt: got %b expected 0001", gnt1); end
    checks++; if (add_a1 !== 2'd1 || add_b1 !== 2'd1) begin failures++; $display("FAIL single_ops: got %0d/%0d expected 1/1", add_a1, add_b1); end
    checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL single_busy_wait: got %b expected 1", busy1); end
    checks++; if (done1 !== 4'b0000) begin failures++; $display("FAIL single_early_done: got %b expected 0000", done1); end
    @(negedge clk);
    i = exp_idx.pop_front(); s = exp_sum.pop_front();
    checks++; if (done1 !== oh(i)) begin failures++; $display("FAIL single_done: got %b expected %b", done1, oh(i)); end
    checks++; if (sum1 !== s) begin failures++; $display("FAIL single_sum: got %0d expected %0d", sum1, s); end
    req1 = 4'b0000;
    @(negedge clk);
    checks++; if (busy1 !== 1'b0 || gnt1 !== 4'b0000) begin failures++; $display("FAIL single_idle: got busy=%b gnt=%b expected 0/0000", busy1, gnt1); end
  endtask

  task automatic test_rotation();
    bit ok;
    int i, prev;
    logic [2:0] s;
    apply_reset();
    a1 = 8'hFF; b1 = 8'hFF;
    req1 = 4'hF;
    for (int k = 0; k < 5; k++) push(k % N, 3, 3);
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_done1(8, ok);
      i = exp_idx.pop_front(); s = exp_sum.pop_front();
      checks++;
      if (!ok) begin
        failures++; $display("FAIL rotation_timeout: got no done expected done %b", oh(i));
      end else if (done1 !== oh(i) || sum1 !== s || gnt1 !== oh(i)) begin
        failures++; $display("FAIL rotation_txn%0d: got done=%b gnt=%b sum=%0d expected %b/%b/%0d", k, done1, gnt1, sum1, oh(i), oh(i), s);
      end
      if (k > 0) begin
        checks++;
        if (cyc - prev != 3) begin failures++; $display("FAIL rotation_spacing: got %0d expected 3", cyc - prev); end
      end
      prev = cyc;
    end
    req1 = 4'h0;
    @(negedge clk);
  endtask

  task automatic test_ptr_wrap();
    bit ok;
    int i;
    logic [2:0] s;
    req1 = 4'b0010;
    a1 = 8'h00; b1 = 8'h00;
    set_op1(1, 2'd1, 2'd1);
    push(1, 1, 1);
    for (int k = 0; k < 3; k++) begin
      wait_done1(8, ok);
      i = exp_idx.pop_front(); s = exp_sum.pop_front();
      checks++;
      if (!ok) begin
        failures++; $display("FAIL ptr_timeout: got no done expected done %b", oh(i));
      end else if (done1 !== oh(i) || sum1 !== s) begin
        failures++; $display("FAIL ptr_txn%0d: got done=%b sum=%0d expected %b/%0d", k, done1, sum1, oh(i), s);
      end
      if (k == 0) begin
        req1 = 4'b0011;
        set_op1(0, 2'd1, 2'd2);
        set_op1(1, 2'd2, 2'd2);
        push(0, 1, 2);
        push(1, 2, 2);
      end else begin
        req1 = req1 & ~done1;
      end
    end
    req1 = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int i;
    logic [2:0] s;
    req1 = 4'b0100;
    set_op1(2, 2'd2, 2'd3);
    @(negedge clk);
    checks++; if (gnt1 !== 4'b0100) begin failures++; $display("FAIL rmid_gnt: got %b expected 0100", gnt1); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({gnt1, done1, busy1} !== 9'h0) begin failures++; $display("FAIL rmid_outputs: got gnt=%b done=%b busy=%b expected zeros", gnt1, done1, busy1); end
    checks++; if (sum1 !== 3'd0 || add_a1 !== 2'd0) begin failures++; $display("FAIL rmid_sum: got sum=%0d add_a=%0d expected 0/0", sum1, add_a1); end
    reset = 1'b0;
    push(2, 2, 3);
    wait_done1(8, ok);
    i = exp_idx.pop_front(); s = exp_sum.pop_front();
    checks++;
    if (!ok) begin
      failures++; $display("FAIL rmid_timeout: got no done expected done %b", oh(i));
    end else if (done1 !== oh(i) || sum1 !== s) begin
      failures++; $display("FAIL rmid_txn: got done=%b sum=%0d expected %b/%0d", done1, sum1, oh(i), s);
    end
    req1 = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_latency3();
    int i;
    logic [2:0] s;
    req3 = 4'b0010;
    a3[3:2] = 2'd2; b3[3:2] = 2'd3;
    exp_idx.push_back(1); exp_sum.push_back(3'd5);
    @(negedge clk);
    checks++; if (gnt3 !== 4'b0010) begin failures++; $display("FAIL lat3_gnt: got %b expected 0010", gnt3); end
    req3 = 4'b0000;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      if (k < 4) begin
        checks++;
        if (done3 !== 4'b0000 || busy3 !== 1'b1) begin failures++; $display("FAIL lat3_wait%0d: got done=%b busy=%b expected 0000/1", k, done3, busy3); end
      end else begin
        i = exp_idx.pop_front(); s = exp_sum.pop_front();
        checks++;
        if (done3 !== oh(i) || sum3 !== s) begin failures++; $display("FAIL lat3_done: got done=%b sum=%0d expected %b/%0d", done3, sum3, oh(i), s); end
      end
    end
    @(negedge clk);
    checks++; if (busy3 !== 1'b0 || gnt3 !== 4'b0000) begin failures++; $display("FAIL lat3_idle: got busy=%b gnt=%b expected 0/0000", busy3, gnt3); end
  endtask

  task automatic test_operand_hold();
    int i;
    logic [2:0] s;
    req1 = 4'b0001;
    set_op1(0, 2'd1, 2'd0);
    push(0, 1, 0);
    @(negedge clk);
    checks++; if (add_a1 !== 2'd1) begin failures++; $display("FAIL hold_latched: got %0d expected 1", add_a1); end
    set_op1(0, 2'd3, 2'd0);
    @(negedge clk);
    i = exp_idx.pop_front(); s = exp_sum.pop_front();
    checks++;
    if (done1 !== oh(i) || sum1 !== s) begin failures++; $display("FAIL hold_sum: got done=%b sum=%0d expected %b/%0d", done1, sum1, oh(i), s); end
    req1 = 4'b0000;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_ptr_wrap();
    test_reset_mid();
    test_latency3();
    test_operand_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
